// File: rtl/fpu_dma_sequencer_if.sv
// Bundles the controller request, ping-pong buffer ports and memory beat bus of
// the FPU DMA sequencer. The master side is the sequencer itself.
interface fpu_dma_sequencer_if #(
    parameter int COL_WIDTH        = 10,
    parameter int MEM_BUFFER_WIDTH = 512,
    parameter int BEAT_BYTES       = 64
);
    localparam int RW = $clog2(COL_WIDTH);
    localparam int BW = $clog2(MEM_BUFFER_WIDTH / BEAT_BYTES);

    logic                    request_read;
    logic                    request_write;
    logic                    rd_buffer_sel;
    logic [31:0]             read_address;
    logic [31:0]             write_address;
    logic [16:0]             write_request_width;
    logic [8:0]              write_request_height;
    logic [15:0]             image_width;
    logic                    making_request;
    logic                    xfer_done;
    logic                    fill_buf_sel;
    logic                    drain_buf_sel;
    logic                    rbuf_we;
    logic [RW-1:0]           rbuf_row;
    logic [BW-1:0]           rbuf_beat;
    logic [BEAT_BYTES*8-1:0] rbuf_data;
    logic [RW-1:0]           wbuf_row;
    logic [BW-1:0]           wbuf_beat;
    logic [BEAT_BYTES*8-1:0] wbuf_data;
    logic                    mem_rd_req;
    logic                    mem_wr_req;
    logic [31:0]             mem_addr;
    logic [BEAT_BYTES-1:0]   mem_be;
    logic [BEAT_BYTES*8-1:0] mem_wdata;
    logic                    mem_ack;
    logic [BEAT_BYTES*8-1:0] mem_rdata;
    logic [2:0]              dbg_state;

    // Memory beat handshake: mem_rd_req/mem_wr_req act as valid and mem_ack as
    // ready. A beat transfers on a clock edge where both are high; until then
    // mem_addr, mem_be and mem_wdata hold. Ack may coincide with the first
    // request cycle, and the request stays high across consecutive beats.
    modport master (
        input  request_read, request_write, rd_buffer_sel, read_address, write_address,
        input  write_request_width, write_request_height, image_width,
        input  wbuf_data, mem_ack, mem_rdata,
        output making_request, xfer_done, fill_buf_sel, drain_buf_sel,
        output rbuf_we, rbuf_row, rbuf_beat, rbuf_data, wbuf_row, wbuf_beat,
        output mem_rd_req, mem_wr_req, mem_addr, mem_be, mem_wdata, dbg_state
    );

    modport slave (
        output request_read, request_write, rd_buffer_sel, read_address, write_address,
        output write_request_width, write_request_height, image_width,
        output wbuf_data, mem_ack, mem_rdata,
        input  making_request, xfer_done, fill_buf_sel, drain_buf_sel,
        input  rbuf_we, rbuf_row, rbuf_beat, rbuf_data, wbuf_row, wbuf_beat,
        input  mem_rd_req, mem_wr_req, mem_addr, mem_be, mem_wdata, dbg_state
    );
endinterface

// File: rtl/fpu_dma_sequencer.sv
// Fills the idle FPU read buffer from memory and drains the idle write buffer to
// the result image, one memory beat at a time; the write phase runs before the read phase.
module fpu_dma_sequencer #(
    parameter int COL_WIDTH        = 10,
    parameter int MEM_BUFFER_WIDTH = 512,
    parameter int BEAT_BYTES       = 64
) (
    input logic                clk,
    input logic                rst,
    fpu_dma_sequencer_if.master bus
);
    localparam int BEATS = MEM_BUFFER_WIDTH / BEAT_BYTES;
    localparam int RW    = $clog2(COL_WIDTH);
    localparam int BW    = $clog2(BEATS);
    localparam int OW    = $clog2(BEAT_BYTES);
    localparam int WW    = $clog2(MEM_BUFFER_WIDTH) + 1;
    localparam logic [RW-1:0]         RD_LAST_ROW  = RW'(COL_WIDTH - 1);
    localparam logic [BW-1:0]         RD_LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BEAT_BYTES-1:0] BE_ALL       = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BEAT = 3'd1,
        RD_BEAT = 3'd2,
        RD_LAST = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic                    do_rd_q;
    logic                    buf_sel_q;
    logic [31:0]             rd_base_q;
    logic [31:0]             row_base_q;
    logic [15:0]             img_q;
    logic [RW-1:0]           wr_last_row_q;
    logic [BW-1:0]           wr_last_beat_q;
    logic [OW-1:0]           wr_rem_q;
    logic [RW-1:0]           row_q;
    logic [BW-1:0]           beat_q;
    logic                    rbuf_we_q;
    logic [RW-1:0]           rbuf_row_q;
    logic [BW-1:0]           rbuf_beat_q;
    logic [BEAT_BYTES*8-1:0] rbuf_data_q;

    logic          req;
    logic          wr_ok;
    logic [WW-1:0] w_clip;
    logic [WW:0]   w_sum;
    logic [RW-1:0] h_last;
    logic [BW-1:0] w_last_beat;
    logic [31:0]   img3;
    logic [31:0]   stride;
    logic [31:0]   cur_addr;
    logic          row_end;
    logic          last_row;

    // Request geometry is clipped to the buffer size before it is latched.
    always_comb begin
        req    = bus.request_read | bus.request_write;
        w_clip = (bus.write_request_width > 17'(MEM_BUFFER_WIDTH)) ? WW'(MEM_BUFFER_WIDTH)
                                                                   : bus.write_request_width[WW-1:0];
        w_sum  = {1'b0, w_clip} + (WW+1)'(BEAT_BYTES - 1);
        w_last_beat = BW'((w_sum >> OW) - (WW+1)'(1));
        h_last = (bus.write_request_height > 9'(COL_WIDTH)) ? RD_LAST_ROW
                                                            : RW'(bus.write_request_height - 9'd1);
        wr_ok  = bus.request_write && (w_clip != '0) && (bus.write_request_height != '0);
    end

    // Row pitch: drain rows are image_width*3+4 bytes apart, fill rows (image_width+2)*3.
    always_comb begin
        img3     = ({16'b0, img_q} << 1) + {16'b0, img_q};
        stride   = (state_q == WR_BEAT) ? img3 + 32'd4 : img3 + 32'd6;
        cur_addr = row_base_q + (32'(beat_q) << OW);
        row_end  = (state_q == WR_BEAT) ? (beat_q == wr_last_beat_q) : (beat_q == RD_LAST_BEAT);
        last_row = (state_q == WR_BEAT) ? (row_q == wr_last_row_q) : (row_q == RD_LAST_ROW);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        bus.making_request = 1'b0;
        bus.xfer_done      = 1'b0;
        bus.mem_rd_req     = 1'b0;
        bus.mem_wr_req     = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_be         = '0;
        bus.mem_wdata      = '0;
        bus.wbuf_row       = '0;
        bus.wbuf_beat      = '0;
        case (state_q)
            IDLE: begin
                if (req) state_d = wr_ok ? WR_BEAT : (bus.request_read ? RD_BEAT : DONE);
            end
            WR_BEAT: begin
                bus.making_request = 1'b1;
                bus.mem_wr_req     = 1'b1;
                bus.mem_addr       = cur_addr;
                bus.mem_be         = (row_end && wr_rem_q != '0) ? ~(BE_ALL << wr_rem_q) : BE_ALL;
                bus.mem_wdata      = bus.wbuf_data;
                bus.wbuf_row       = row_q;
                bus.wbuf_beat      = beat_q;
                if (bus.mem_ack && row_end && last_row) state_d = do_rd_q ? RD_BEAT : DONE;
            end
            RD_BEAT: begin
                bus.making_request = 1'b1;
                bus.mem_rd_req     = 1'b1;
                bus.mem_addr       = cur_addr;
                bus.mem_be         = BE_ALL;
                if (bus.mem_ack && row_end && last_row) state_d = RD_LAST;
            end
            RD_LAST: begin
                bus.making_request = 1'b1;
                state_d            = DONE;
            end
            DONE: begin
                bus.xfer_done = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters and the registered read-buffer write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            do_rd_q        <= 1'b0;
            buf_sel_q      <= 1'b0;
            rd_base_q      <= '0;
            row_base_q     <= '0;
            img_q          <= '0;
            wr_last_row_q  <= '0;
            wr_last_beat_q <= '0;
            wr_rem_q       <= '0;
            row_q          <= '0;
            beat_q         <= '0;
            rbuf_we_q      <= 1'b0;
            rbuf_row_q     <= '0;
            rbuf_beat_q    <= '0;
            rbuf_data_q    <= '0;
        end else begin
            rbuf_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        do_rd_q        <= bus.request_read;
                        buf_sel_q      <= !bus.rd_buffer_sel;
                        rd_base_q      <= bus.read_address;
                        img_q          <= bus.image_width;
                        wr_last_row_q  <= h_last;
                        wr_last_beat_q <= w_last_beat;
                        wr_rem_q       <= w_clip[OW-1:0];
                        row_q          <= '0;
                        beat_q         <= '0;
                        row_base_q     <= wr_ok ? bus.write_address : bus.read_address;
                    end
                end
                WR_BEAT, RD_BEAT: begin
                    if (bus.mem_ack) begin
                        if (state_q == RD_BEAT) begin
                            rbuf_we_q   <= 1'b1;
                            rbuf_row_q  <= row_q;
                            rbuf_beat_q <= beat_q;
                            rbuf_data_q <= bus.mem_rdata;
                        end
                        if (row_end && last_row) begin
                            row_q      <= '0;
                            beat_q     <= '0;
                            row_base_q <= rd_base_q;
                        end else if (row_end) begin
                            beat_q     <= '0;
                            row_q      <= row_q + RW'(1);
                            row_base_q <= row_base_q + stride;
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rbuf_we       = rbuf_we_q;
    assign bus.rbuf_row      = rbuf_row_q;
    assign bus.rbuf_beat     = rbuf_beat_q;
    assign bus.rbuf_data     = rbuf_data_q;
    assign bus.fill_buf_sel  = buf_sel_q;
    assign bus.drain_buf_sel = buf_sel_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_fpu_dma_sequencer.sv
// Directed bench for fpu_dma_sequencer: a memory responder logs every beat and
// read-buffer write, and each test task checks the logs against hand-derived tables.
`timescale 1ns/1ps
module tb_fpu_dma_sequencer;
    localparam int BB    = 64;
    localparam int DW    = BB * 8;
    localparam int LIMIT = 20000;
    localparam logic [BB-1:0] BE_ALL = '1;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_dma_sequencer_if bus ();
    fpu_dma_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // beat and buffer-write logs filled by the responder
    logic [31:0]   log_addr[$];
    logic [BB-1:0] log_be[$];
    logic          log_wr[$];
    logic [DW-1:0] log_wdata[$];
    logic [3:0]    we_row[$];
    logic [2:0]    we_beat[$];
    logic [DW-1:0] we_data[$];
    int            done_cnt  = 0;
    int            hold_bad  = 0;
    int            both_req  = 0;
    int            ack_max   = 0;
    int            wait_left = -1;
    logic [31:0]   held_addr = '0;

    // scoreboard expectations
    logic [31:0]   exp_q[$];
    logic [BB-1:0] exp_be_q[$];
    logic          exp_wr_q[$];

    int   cyc;
    logic busy;
    int   bad;
    int   first_bad;

    function automatic logic [DW-1:0] fill_pat(input logic [31:0] a);
        return {16{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [DW-1:0] wbuf_pat(input logic [3:0] r, input logic [2:0] b);
        return {64{r, 1'b1, b}};
    endfunction

    assign bus.wbuf_data = wbuf_pat(bus.wbuf_row, bus.wbuf_beat);

    // memory responder and monitors
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.xfer_done) done_cnt++;
            if (bus.mem_rd_req && bus.mem_wr_req) both_req++;
            if (bus.rbuf_we) begin
                we_row.push_back(bus.rbuf_row);
                we_beat.push_back(bus.rbuf_beat);
                we_data.push_back(bus.rbuf_data);
            end
            if (rst || !(bus.mem_rd_req || bus.mem_wr_req)) begin
                wait_left = -1;
            end else begin
                if (wait_left < 0) begin
                    wait_left = (ack_max > 0) ? int'($urandom_range(0, ack_max)) : 0;
                    held_addr = bus.mem_addr;
                end else if (bus.mem_addr !== held_addr) begin
                    hold_bad++;
                end
                if (wait_left == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = fill_pat(bus.mem_addr);
                    log_addr.push_back(bus.mem_addr);
                    log_be.push_back(bus.mem_be);
                    log_wr.push_back(bus.mem_wr_req);
                    log_wdata.push_back(bus.mem_wdata);
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // driver tasks
    task automatic clear_logs();
        log_addr.delete(); log_be.delete(); log_wr.delete(); log_wdata.delete();
        we_row.delete(); we_beat.delete(); we_data.delete();
        exp_q.delete(); exp_be_q.delete(); exp_wr_q.delete();
        done_cnt = 0; hold_bad = 0; both_req = 0;
    endtask

    task automatic push_fill(input logic [31:0] base, input int pitch);
        for (int r = 0; r < 10; r++)
            for (int b = 0; b < 8; b++) begin
                exp_q.push_back(base + 32'(r * pitch + b * 64));
                exp_be_q.push_back(BE_ALL);
                exp_wr_q.push_back(1'b0);
            end
    endtask

    task automatic run_xfer(input logic rr, input logic rw, input logic sel,
                            input logic [31:0] ra, input logic [31:0] wa,
                            input logic [16:0] w, input logic [8:0] h,
                            input logic [15:0] img, input logic toggle,
                            output int cyc_o, output logic busy_o);
        @(negedge clk);
        bus.rd_buffer_sel        = sel;
        bus.read_address         = ra;
        bus.write_address        = wa;
        bus.write_request_width  = w;
        bus.write_request_height = h;
        bus.image_width          = img;
        bus.request_read         = rr;
        bus.request_write        = rw;
        @(negedge clk);
        busy_o            = bus.making_request;
        bus.request_read  = 1'b0;
        bus.request_write = 1'b0;
        cyc_o = 0;
        while (!bus.xfer_done && cyc_o < LIMIT) begin
            if (toggle) begin
                bus.request_read  = 1'($urandom_range(0, 1));
                bus.request_write = 1'($urandom_range(0, 1));
                bus.read_address  = $urandom;
                bus.write_address = $urandom;
            end
            @(negedge clk);
            cyc_o++;
        end
        bus.request_read  = 1'b0;
        bus.request_write = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // test tasks
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.making_request, bus.xfer_done, bus.mem_rd_req, bus.mem_wr_req, bus.rbuf_we,
             bus.fill_buf_sel, bus.drain_buf_sel} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000000", {bus.making_request, bus.xfer_done,
                     bus.mem_rd_req, bus.mem_wr_req, bus.rbuf_we, bus.fill_buf_sel, bus.drain_buf_sel});
        end
        n_cmp++;
        if (bus.mem_addr !== 32'd0 || bus.mem_be !== '0) begin
            n_bad++;
            $display("FAIL reset_bus: addr %0d be %h want 0 0", bus.mem_addr, bus.mem_be);
        end
        n_cmp++;
        if (bus.dbg_state !== 3'd0 || bus.rbuf_data !== '0) begin
            n_bad++;
            $display("FAIL reset_state: state %0d want 0", bus.dbg_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_only();
        clear_logs();
        push_fill(32'd0, 486);
        run_xfer(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 17'd0, 9'd0, 16'd160, 1'b0, cyc, busy);
        n_cmp++;
        if (cyc >= LIMIT || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL t1_busy: cycles %0d busy %b want <%0d 1", cyc, busy, LIMIT);
        end
        bad = 0; first_bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= log_addr.size() || log_addr[i] !== exp_q[i] || log_be[i] !== exp_be_q[i] ||
                log_wr[i] !== exp_wr_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        n_cmp++;
        if (bad != 0 || log_addr.size() != 80) begin
            n_bad++;
            $display("FAIL t1_beats: %0d beats (want 80), %0d bad, first bad %0d want addr %0d",
                     log_addr.size(), bad, first_bad, (first_bad >= 0) ? exp_q[first_bad] : 0);
        end
        bad = 0;
        for (int i = 0; i < 80; i++)
            if (i >= we_row.size() || we_row[i] !== 4'(i / 8) || we_beat[i] !== 3'(i % 8) ||
                we_data[i] !== fill_pat(exp_q[i])) bad++;
        n_cmp++;
        if (bad != 0 || we_row.size() != 80) begin
            n_bad++;
            $display("FAIL t1_rbuf: %0d writes (want 80), %0d bad (want 0)", we_row.size(), bad);
        end
        n_cmp++;
        if (done_cnt != 1 || bus.making_request !== 1'b0 || both_req != 0) begin
            n_bad++;
            $display("FAIL t1_done: done %0d busy %b both %0d want 1 0 0", done_cnt, bus.making_request, both_req);
        end
        n_cmp++;
        if (bus.fill_buf_sel !== 1'b1) begin
            n_bad++;
            $display("FAIL t1_fill_sel: got %b want 1", bus.fill_buf_sel);
        end
    endtask

    task automatic test_write_only();
        logic [31:0] addrs[6];
        addrs = '{32'd5168, 32'd5232, 32'd5268, 32'd5332, 32'd5368, 32'd5432};
        clear_logs();
        run_xfer(1'b0, 1'b1, 1'b0, 32'd0, 32'd5168, 17'd100, 9'd3, 16'd32, 1'b0, cyc, busy);
        n_cmp++;
        if (cyc >= LIMIT || busy !== 1'b1 || log_addr.size() != 6) begin
            n_bad++;
            $display("FAIL t2_count: beats %0d busy %b want 6 1", log_addr.size(), busy);
        end
        bad = 0;
        for (int i = 0; i < 6; i++)
            if (i >= log_addr.size() || log_addr[i] !== addrs[i] || log_wr[i] !== 1'b1 ||
                log_be[i] !== ((i % 2 == 1) ? 64'h0000_000F_FFFF_FFFF : BE_ALL)) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL t2_addr_be: %0d bad beats want 0 (first addr %0d want 5168)",
                     bad, (log_addr.size() > 0) ? log_addr[0] : 0);
        end
        bad = 0;
        for (int i = 0; i < log_wdata.size(); i++)
            if (log_wdata[i] !== wbuf_pat(4'(i / 2), 3'(i % 2))) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL t2_wdata: %0d bad beats want 0", bad);
        end
        n_cmp++;
        if (we_row.size() != 0 || done_cnt != 1 || bus.drain_buf_sel !== 1'b1) begin
            n_bad++;
            $display("FAIL t2_done: rbuf_we %0d done %0d drain_sel %b want 0 1 1",
                     we_row.size(), done_cnt, bus.drain_buf_sel);
        end
    endtask

    task automatic test_both();
        logic [31:0] addrs[6];
        addrs = '{32'd5168, 32'd5232, 32'd5268, 32'd5332, 32'd5368, 32'd5432};
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(addrs[i]);
            exp_be_q.push_back((i % 2 == 1) ? 64'h0000_000F_FFFF_FFFF : BE_ALL);
            exp_wr_q.push_back(1'b1);
        end
        push_fill(32'd1000, 102);
        run_xfer(1'b1, 1'b1, 1'b1, 32'd1000, 32'd5168, 17'd100, 9'd3, 16'd32, 1'b0, cyc, busy);
        bad = 0; first_bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= log_addr.size() || log_addr[i] !== exp_q[i] || log_be[i] !== exp_be_q[i] ||
                log_wr[i] !== exp_wr_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        n_cmp++;
        if (bad != 0 || log_addr.size() != 86) begin
            n_bad++;
            $display("FAIL t3_order: %0d beats (want 86), %0d bad, first bad %0d", log_addr.size(), bad, first_bad);
        end
        n_cmp++;
        if (bus.fill_buf_sel !== 1'b0 || bus.drain_buf_sel !== 1'b0) begin
            n_bad++;
            $display("FAIL t3_buf_sel: fill %b drain %b want 0 0", bus.fill_buf_sel, bus.drain_buf_sel);
        end
        n_cmp++;
        if (we_row.size() != 80 || done_cnt != 1 || both_req != 0) begin
            n_bad++;
            $display("FAIL t3_done: rbuf_we %0d done %0d both %0d want 80 1 0", we_row.size(), done_cnt, both_req);
        end
    endtask

    task automatic test_zero_width();
        clear_logs();
        push_fill(32'd0, 486);
        run_xfer(1'b1, 1'b1, 1'b0, 32'd0, 32'd4096, 17'd0, 9'd3, 16'd160, 1'b0, cyc, busy);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= log_addr.size() || log_addr[i] !== exp_q[i] || log_wr[i] !== 1'b0) bad++;
        n_cmp++;
        if (bad != 0 || log_addr.size() != 80) begin
            n_bad++;
            $display("FAIL t4_read_only: %0d beats (want 80), %0d bad (want 0)", log_addr.size(), bad);
        end
        clear_logs();
        run_xfer(1'b0, 1'b1, 1'b0, 32'd0, 32'd4096, 17'd64, 9'd0, 16'd160, 1'b0, cyc, busy);
        n_cmp++;
        if (log_addr.size() != 0 || done_cnt != 1 || busy !== 1'b0 || cyc != 0) begin
            n_bad++;
            $display("FAIL t4_zero_write: beats %0d done %0d busy %b cyc %0d want 0 1 0 0",
                     log_addr.size(), done_cnt, busy, cyc);
        end
    endtask

    task automatic test_clip();
        clear_logs();
        for (int r = 0; r < 10; r++)
            for (int b = 0; b < 8; b++) exp_q.push_back(32'(8192 + r * 484 + b * 64));
        run_xfer(1'b0, 1'b1, 1'b0, 32'd0, 32'd8192, 17'd600, 9'd12, 16'd160, 1'b0, cyc, busy);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= log_addr.size() || log_addr[i] !== exp_q[i] || log_be[i] !== BE_ALL ||
                log_wr[i] !== 1'b1) bad++;
        n_cmp++;
        if (bad != 0 || log_addr.size() != 80) begin
            n_bad++;
            $display("FAIL clip: %0d beats (want 80), %0d bad (want 0)", log_addr.size(), bad);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        @(negedge clk);
        bus.read_address = 32'd0;
        bus.image_width  = 16'd160;
        bus.rd_buffer_sel = 1'b0;
        bus.request_read = 1'b1;
        @(negedge clk);
        bus.request_read = 1'b0;
        n = 0;
        while (log_addr.size() < 20 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.making_request, bus.mem_rd_req, bus.mem_wr_req, bus.rbuf_we, bus.xfer_done,
             bus.fill_buf_sel} !== 6'b0 || bus.mem_addr !== 32'd0 || bus.dbg_state !== 3'd0) begin
            n_bad++;
            $display("FAIL t5_after_rst: busy %b rd %b we %b addr %0d state %0d want 0 0 0 0 0",
                     bus.making_request, bus.mem_rd_req, bus.rbuf_we, bus.mem_addr, bus.dbg_state);
        end
        rst = 1'b0;
        clear_logs();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (log_addr.size() != 0 || done_cnt != 0) begin
            n_bad++;
            $display("FAIL t5_aborted: beats %0d done %0d want 0 0", log_addr.size(), done_cnt);
        end
        clear_logs();
        push_fill(32'd0, 486);
        run_xfer(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 17'd0, 9'd0, 16'd160, 1'b0, cyc, busy);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= log_addr.size() || log_addr[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (bad != 0 || log_addr.size() != 80 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL t5_restart: beats %0d bad %0d done %0d want 80 0 1", log_addr.size(), bad, done_cnt);
        end
    endtask

    task automatic test_random_ack();
        logic [31:0] addrs[6];
        int extra;
        addrs = '{32'd5168, 32'd5232, 32'd5268, 32'd5332, 32'd5368, 32'd5432};
        clear_logs();
        for (int i = 0; i < 6; i++) exp_q.push_back(addrs[i]);
        push_fill(32'h2000, 102);
        ack_max = 100;
        run_xfer(1'b1, 1'b1, 1'b0, 32'h2000, 32'd5168, 17'd100, 9'd3, 16'd32, 1'b1, cyc, busy);
        ack_max = 0;
        n_cmp++;
        if (cyc >= LIMIT || hold_bad != 0) begin
            n_bad++;
            $display("FAIL t6_hold: cycles %0d addr changes while waiting %0d want <%0d 0", cyc, hold_bad, LIMIT);
        end
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= log_addr.size() || log_addr[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (bad != 0 || log_addr.size() != 86) begin
            n_bad++;
            $display("FAIL t6_addrs: beats %0d bad %0d want 86 0", log_addr.size(), bad);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.making_request) extra++;
        end
        n_cmp++;
        if (extra != 0 || done_cnt != 1 || log_addr.size() != 86) begin
            n_bad++;
            $display("FAIL t6_no_extra: busy cycles %0d done %0d beats %0d want 0 1 86",
                     extra, done_cnt, log_addr.size());
        end
    endtask

    initial begin
        bus.request_read         = 1'b0;
        bus.request_write        = 1'b0;
        bus.rd_buffer_sel        = 1'b0;
        bus.read_address         = '0;
        bus.write_address        = '0;
        bus.write_request_width  = '0;
        bus.write_request_height = '0;
        bus.image_width          = '0;
        test_reset();
        test_read_only();
        test_write_only();
        test_both();
        test_zero_width();
        test_clip();
        test_reset_mid();
        test_random_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
